// File: rtl/axis_i2c_ctrl_if.sv
// Stream, command-FIFO and I2C-engine handshake signals of axis_i2c_ctrl.
// The slave modport is the controller's view; master is the environment's.
interface axis_i2c_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7
);
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tlast;
   logic                  s_axis_tready;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic [ADDR_WIDTH-1:0] fifo_addr;
   logic                  fifo_wr_en;
   logic                  fifo_full;
   logic                  fifo_rd_en;
   logic                  fifo_empty;
   logic                  fsm_ready;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full, fifo_empty, fsm_ready,
      output s_axis_tready, fifo_data, fifo_addr, fifo_wr_en, fifo_rd_en
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full, fifo_empty, fsm_ready,
      input  s_axis_tready, fifo_data, fifo_addr, fifo_wr_en, fifo_rd_en
   );
endinterface

// File: rtl/axis_i2c_ctrl.sv
// AXI-Stream packets (address beat + data beats) are split into {addr, data}
// FIFO entries; an independent dispatcher starts the I2C engine once per entry.
module axis_i2c_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 7,
   parameter int BUSY_TIMEOUT = 1023,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   axis_i2c_ctrl_if.slave       bus,
   output logic                 busy,
   output logic                 timeout_err,
   output logic                 empty_pkt_err,
   output logic [CNT_WIDTH-1:0] done_cnt
);
   localparam int TMO_WIDTH = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic {ING_ADDR, ING_DATA} ingest_e;
   typedef enum logic [1:0] {DSP_IDLE, DSP_ISSUE, DSP_WAIT_BUSY, DSP_WAIT_DONE} dispatch_e;

   ingest_e               ing_q, ing_d;
   dispatch_e             dsp_q, dsp_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
   logic [CNT_WIDTH-1:0]  done_q, done_d;
   logic                  timeout_q, timeout_d;
   logic                  empty_pkt_q, empty_pkt_d;
   logic [DATA_WIDTH-1:0] beat;
   logic                  tready, wr_en, rd_en;

   assign beat = bus.s_axis_tdata;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (arst) begin
         ing_q       <= ING_ADDR;
         dsp_q       <= DSP_IDLE;
         addr_q      <= '0;
         tmo_q       <= '0;
         done_q      <= '0;
         timeout_q   <= 1'b0;
         empty_pkt_q <= 1'b0;
      end else begin
         ing_q       <= ing_d;
         dsp_q       <= dsp_d;
         addr_q      <= addr_d;
         tmo_q       <= tmo_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         empty_pkt_q <= empty_pkt_d;
      end
   end

   // NOTE: every always_comb output gets a default first, otherwise a missing branch infers a latch.
   always_comb begin
      ing_d       = ing_q;
      addr_d      = addr_q;
      empty_pkt_d = 1'b0;
      tready      = 1'b0;
      wr_en       = 1'b0;
      unique case (ing_q)
         ING_ADDR: begin
            tready = 1'b1;
            if (bus.s_axis_tvalid) begin
               addr_d = beat[ADDR_WIDTH-1:0];
               if (bus.s_axis_tlast) empty_pkt_d = 1'b1;
               else                  ing_d       = ING_DATA;
            end
         end
         ING_DATA: begin
            tready = !bus.fifo_full;
            if (bus.s_axis_tvalid && tready) begin
               wr_en = 1'b1;
               if (bus.s_axis_tlast) ing_d = ING_ADDR;
            end
         end
         default: ing_d = ING_ADDR;
      endcase
      // Reset is synchronous, so outputs are masked during the cycle it is held.
      if (arst) begin
         tready = 1'b0;
         wr_en  = 1'b0;
      end
   end

   always_comb begin
      dsp_d     = dsp_q;
      tmo_d     = tmo_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      rd_en     = 1'b0;
      unique case (dsp_q)
         DSP_IDLE:
            if (!bus.fifo_empty && bus.fsm_ready && !timeout_q) dsp_d = DSP_ISSUE;
         DSP_ISSUE: begin
            rd_en = 1'b1;
            tmo_d = '0;
            dsp_d = DSP_WAIT_BUSY;
         end
         DSP_WAIT_BUSY: begin
            if (!bus.fsm_ready) begin
               dsp_d = DSP_WAIT_DONE;
            end else if (tmo_q == TMO_WIDTH'(BUSY_TIMEOUT - 1)) begin
               // Engine never acknowledged the start within BUSY_TIMEOUT cycles.
               timeout_d = 1'b1;
               dsp_d     = DSP_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DSP_WAIT_DONE:
            if (bus.fsm_ready) begin
               done_d = done_q + 1'b1;
               dsp_d  = DSP_IDLE;
            end
         default: dsp_d = DSP_IDLE;
      endcase
      if (arst) rd_en = 1'b0;
   end

   assign bus.s_axis_tready = tready;
   assign bus.fifo_wr_en    = wr_en;
   assign bus.fifo_data     = beat;
   assign bus.fifo_addr     = addr_q;
   assign bus.fifo_rd_en    = rd_en;
   assign busy              = (dsp_q != DSP_IDLE) && !arst;
   assign timeout_err       = timeout_q;
   assign empty_pkt_err     = empty_pkt_q;
   assign done_cnt          = done_q;
endmodule
